dl_sequencer: RTL and testbench

DL_SEQUENCER -- requirements
Module: dl_sequencer

---
 rtl/zigzag_pkg.sv | 26 ++
 rtl/reset_stretch.sv | 31 +++
 rtl/dl_sequencer.sv | 151 +++++++++++++++
 tb/tb_dl_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zigzag_pkg.sv
// Shared definitions for the ROM download sequencer: state encoding,
// default region boundaries and the byte-count update rule.
package zigzag_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } state_e;

  localparam logic [15:0] CPU_END_DEF  = 16'h4000;
  localparam logic [15:0] GFX_END_DEF  = 16'h5000;
  localparam logic [16:0] PROM_END_DEF = 17'h05020;
  localparam logic [16:0] COUNT_MAX    = 17'h1FFFF;

  // High-water mark of addr+1, clamped to the counter range.
  function automatic logic [16:0] next_count(input logic [16:0] cur,
                                             input logic [15:0] addr);
    logic [17:0] top;
    top = {2'b00, addr} + 18'd1;
    if (top > {1'b0, COUNT_MAX}) top = {1'b0, COUNT_MAX};
    return (top[16:0] > cur) ? top[16:0] : cur;
  endfunction

endpackage

// File: rtl/reset_stretch.sv
// Counts HOLD cycles after a load or user reset; done is raised in the
// final cycle so the owner can leave HOLD on the following edge.
module reset_stretch #(
  parameter int HOLD = 16
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic clear_i,
  input  logic en_i,
  output logic done_o
);

  localparam int W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [W-1:0] LAST = W'(HOLD - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) cnt_d = '0;
    else if (en_i && (cnt_q != LAST)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign done_o = en_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/dl_sequencer.sv
// Routes HPS ROM download bytes to the CPU/graphics/PROM regions, tracks
// load completeness and holds the game core in reset until it is safe to run.
module dl_sequencer
  import zigzag_pkg::*;
#(
  parameter logic [15:0] CPU_END    = CPU_END_DEF,
  parameter logic [15:0] GFX_END    = GFX_END_DEF,
  parameter logic [16:0] PROM_END   = PROM_END_DEF,
  parameter int          RESET_HOLD = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [15:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        user_reset,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr_cpu,
  output logic        dn_wr_gfx,
  output logic        dn_wr_prom,
  output logic        core_reset,
  output logic        load_ok,
  output logic        load_short,
  output logic        load_over,
  output logic [16:0] byte_count
);

  state_e      state_q, state_d;
  logic        dl_q, user_q;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        cpu_q, cpu_d, gfx_q, gfx_d, prom_q, prom_d;
  logic        core_reset_q, core_reset_d;
  logic        ok_q, ok_d, short_q, short_d, over_q, over_d;
  logic [16:0] count_q, count_d;
  logic        rise, fall, accept, in_range;
  logic        hold_en, hold_clear, hold_done;

  assign rise     = ioctl_download && !dl_q;
  assign fall     = !ioctl_download && dl_q;
  assign in_range = {1'b0, ioctl_addr} < PROM_END;
  // The write that shares a cycle with the download falling edge still counts.
  assign accept   = (state_q == LOAD) && ioctl_wr && (ioctl_download || dl_q);

  // user_q stretches the clear by one cycle so HOLD always lasts RESET_HOLD
  // cycles after user_reset is released, matching the load case.
  assign hold_en    = (state_q == HOLD);
  assign hold_clear = !hold_en || user_reset || user_q;

  reset_stretch #(.HOLD(RESET_HOLD)) u_hold (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .clear_i (hold_clear),
    .en_i    (hold_en),
    .done_o  (hold_done)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cpu_d   = 1'b0;
    gfx_d   = 1'b0;
    prom_d  = 1'b0;
    count_d = count_q;
    ok_d    = ok_q;
    short_d = short_q;
    over_d  = over_q;

    if (accept) begin
      addr_d  = ioctl_addr;
      data_d  = ioctl_dout;
      count_d = next_count(count_q, ioctl_addr);
      if (ioctl_addr < CPU_END)      cpu_d  = 1'b1;
      else if (ioctl_addr < GFX_END) gfx_d  = 1'b1;
      else if (in_range)             prom_d = 1'b1;
      else                           over_d = 1'b1;
    end

    case (state_q)
      BOOT: if (ioctl_download) state_d = LOAD;
      LOAD: begin
        if (fall) begin
          state_d = HOLD;
          short_d = (count_d < PROM_END);
          ok_d    = !(count_d < PROM_END) && !over_d;
        end
      end
      HOLD:    if (hold_done) state_d = RUN;
      RUN:     if (user_reset) state_d = HOLD;
      default: state_d = BOOT;
    endcase

    if (rise && (state_q != LOAD)) state_d = LOAD;

    if ((state_d == LOAD) && (state_q != LOAD)) begin
      count_d = '0;
      ok_d    = 1'b0;
      short_d = 1'b0;
      over_d  = 1'b0;
    end

    core_reset_d = (state_d != RUN);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= BOOT;
      dl_q         <= 1'b0;
      user_q       <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      cpu_q        <= 1'b0;
      gfx_q        <= 1'b0;
      prom_q       <= 1'b0;
      core_reset_q <= 1'b1;
      ok_q         <= 1'b0;
      short_q      <= 1'b0;
      over_q       <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      dl_q         <= ioctl_download;
      user_q       <= user_reset;
      addr_q       <= addr_d;
      data_q       <= data_d;
      cpu_q        <= cpu_d;
      gfx_q        <= gfx_d;
      prom_q       <= prom_d;
      core_reset_q <= core_reset_d;
      ok_q         <= ok_d;
      short_q      <= short_d;
      over_q       <= over_d;
      count_q      <= count_d;
    end
  end

  assign dn_addr    = addr_q;
  assign dn_data    = data_q;
  assign dn_wr_cpu  = cpu_q;
  assign dn_wr_gfx  = gfx_q;
  assign dn_wr_prom = prom_q;
  assign core_reset = core_reset_q;
  assign load_ok    = ok_q;
  assign load_short = short_q;
  assign load_over  = over_q;
  assign byte_count = count_q;

endmodule

// File: tb/tb_dl_sequencer.sv
// Directed self-checking bench for dl_sequencer: full, short, overrun and
// edge-coincident loads, user reset stretching and mid-load reset abort.
module tb_dl_sequencer;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [15:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        user_reset;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr_cpu, dn_wr_gfx, dn_wr_prom;
  logic        core_reset, load_ok, load_short, load_over;
  logic [16:0] byte_count;

  int checks = 0;
  int errors = 0;
  int cpuCnt = 0, gfxCnt = 0, promCnt = 0, badStrobe = 0;

  always #5 clk_sys = ~clk_sys;

  dl_sequencer dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .user_reset     (user_reset),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr_cpu      (dn_wr_cpu),
    .dn_wr_gfx      (dn_wr_gfx),
    .dn_wr_prom     (dn_wr_prom),
    .core_reset     (core_reset),
    .load_ok        (load_ok),
    .load_short     (load_short),
    .load_over      (load_over),
    .byte_count     (byte_count)
  );

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Strobe monitor: counts per region and flags wrong region, data or overlap.
  always @(negedge clk_sys) begin
    if (dn_wr_cpu)  cpuCnt++;
    if (dn_wr_gfx)  gfxCnt++;
    if (dn_wr_prom) promCnt++;
    if ((int'(dn_wr_cpu) + int'(dn_wr_gfx) + int'(dn_wr_prom)) > 1) badStrobe++;
    if (dn_wr_cpu && dn_addr >= 16'h4000) badStrobe++;
    if (dn_wr_gfx && (dn_addr < 16'h4000 || dn_addr >= 16'h5000)) badStrobe++;
    if (dn_wr_prom && (dn_addr < 16'h5000 || dn_addr >= 16'h5020)) badStrobe++;
    if ((dn_wr_cpu || dn_wr_gfx || dn_wr_prom) && dn_data !== pat(dn_addr)) badStrobe++;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic sendRange(input logic [15:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      ioctl_wr   = 1'b1;
      ioctl_addr = start + 16'(i);
      ioctl_dout = pat(start + 16'(i));
    end
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic startDownload();
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    @(negedge clk_sys);
  endtask

  // Drops download, then counts edges after the falling-edge edge until RUN.
  task automatic endDownload(output int n);
    @(negedge clk_sys);
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    @(posedge clk_sys); #1;
    n = 0;
    while (core_reset && n < 100) begin
      @(posedge clk_sys); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; user_reset = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    checks++;
    if (core_reset !== 1'b1 || {dn_wr_cpu, dn_wr_gfx, dn_wr_prom} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: core_reset=%b strobes=%b%b%b want 1 000",
               core_reset, dn_wr_cpu, dn_wr_gfx, dn_wr_prom);
    end
    checks++;
    if (dn_addr !== 16'h0 || dn_data !== 8'h0 || byte_count !== 17'h0 ||
        {load_ok, load_short, load_over} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_data: addr=%h data=%h count=%h flags=%b%b%b want all zero",
               dn_addr, dn_data, byte_count, load_ok, load_short, load_over);
    end
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (5) @(posedge clk_sys);
    #1;
    checks++;
    if (core_reset !== 1'b1) begin
      errors++;
      $display("[TB] FAIL boot_hold: core_reset=%b want 1", core_reset);
    end
  endtask

  task automatic test_idle_write();
    int c0;
    c0 = cpuCnt;
    sendRange(16'h0005, 1);
    @(negedge clk_sys);
    checks++;
    if (cpuCnt !== c0 || dn_addr !== 16'h0 || byte_count !== 17'h0) begin
      errors++;
      $display("[TB] FAIL idle_write: strobes=%0d addr=%h count=%h want 0 0000 0",
               cpuCnt - c0, dn_addr, byte_count);
    end
  endtask

  task automatic test_full_load();
    int n, c0, g0, p0;
    c0 = cpuCnt; g0 = gfxCnt; p0 = promCnt;
    startDownload();
    sendRange(16'h0000, 'h5020);
    endDownload(n);
    checks++;
    if (cpuCnt - c0 !== 'h4000 || gfxCnt - g0 !== 'h1000 || promCnt - p0 !== 'h20) begin
      errors++;
      $display("[TB] FAIL full_strobes: cpu=%h gfx=%h prom=%h want 4000 1000 20",
               cpuCnt - c0, gfxCnt - g0, promCnt - p0);
    end
    checks++;
    if (badStrobe !== 0) begin
      errors++;
      $display("[TB] FAIL strobe_region: bad=%0d want 0", badStrobe);
    end
    checks++;
    if ({load_ok, load_short, load_over} !== 3'b100 || byte_count !== 17'h05020) begin
      errors++;
      $display("[TB] FAIL full_flags: ok/short/over=%b%b%b count=%h want 100 05020",
               load_ok, load_short, load_over, byte_count);
    end
    checks++;
    if (dn_addr !== 16'h501F || dn_data !== pat(16'h501F)) begin
      errors++;
      $display("[TB] FAIL full_hold_data: addr=%h data=%h want 501f %h",
               dn_addr, dn_data, pat(16'h501F));
    end
    checks++;
    if (n !== 16 || core_reset !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_run_delay: cycles=%0d core_reset=%b want 16 0", n, core_reset);
    end
  endtask

  task automatic test_user_reset();
    int n;
    @(negedge clk_sys);
    user_reset = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_sys); #1;
      if (i == 2) user_reset = 1'b0;
      if (core_reset) n++;
      else break;
    end
    checks++;
    if (n !== 19) begin
      errors++;
      $display("[TB] FAIL user_reset_len: high=%0d want 19", n);
    end
  endtask

  task automatic test_short_load();
    int n;
    startDownload();
    checks++;
    if (load_ok !== 1'b0 || byte_count !== 17'h0 || core_reset !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load_entry_clear: ok=%b count=%h core_reset=%b want 0 0 1",
               load_ok, byte_count, core_reset);
    end
    sendRange(16'h0000, 4);
    user_reset = 1'b1;
    sendRange(16'h1234, 2);
    checks++;
    if (core_reset !== 1'b1 || byte_count !== 17'h01236) begin
      errors++;
      $display("[TB] FAIL user_in_load: core_reset=%b count=%h want 1 01236",
               core_reset, byte_count);
    end
    user_reset = 1'b0;
    sendRange(16'h4FFF, 1);
    endDownload(n);
    checks++;
    if ({load_ok, load_short, load_over} !== 3'b010 || byte_count !== 17'h05000) begin
      errors++;
      $display("[TB] FAIL short_flags: ok/short/over=%b%b%b count=%h want 010 05000",
               load_ok, load_short, load_over, byte_count);
    end
    checks++;
    if (n !== 16 || core_reset !== 1'b0) begin
      errors++;
      $display("[TB] FAIL short_run: cycles=%0d core_reset=%b want 16 0", n, core_reset);
    end
  endtask

  task automatic test_over();
    int n;
    startDownload();
    sendRange(16'h0010, 1);
    sendRange(16'h6000, 1);
    checks++;
    if ({dn_wr_cpu, dn_wr_gfx, dn_wr_prom} !== 3'b000 || load_over !== 1'b1 ||
        byte_count !== 17'h06001) begin
      errors++;
      $display("[TB] FAIL over_write: strobes=%b%b%b over=%b count=%h want 000 1 06001",
               dn_wr_cpu, dn_wr_gfx, dn_wr_prom, load_over, byte_count);
    end
    sendRange(16'h5010, 1);
    endDownload(n);
    checks++;
    if ({load_ok, load_short, load_over} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL over_flags: ok/short/over=%b%b%b want 001",
               load_ok, load_short, load_over);
    end
  endtask

  task automatic test_edge_write();
    int n, p0;
    startDownload();
    sendRange(16'h0000, 1);
    p0 = promCnt;
    @(negedge clk_sys);
    ioctl_wr       = 1'b1;
    ioctl_addr     = 16'h501F;
    ioctl_dout     = pat(16'h501F);
    ioctl_download = 1'b0;
    @(posedge clk_sys); #1;
    checks++;
    if (dn_wr_prom !== 1'b1 || dn_addr !== 16'h501F || byte_count !== 17'h05020 ||
        load_ok !== 1'b1 || load_short !== 1'b0) begin
      errors++;
      $display("[TB] FAIL edge_write: prom=%b addr=%h count=%h ok=%b short=%b want 1 501f 05020 1 0",
               dn_wr_prom, dn_addr, byte_count, load_ok, load_short);
    end
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    n = 0;
    while (core_reset && n < 100) begin
      @(posedge clk_sys); #1;
      n++;
    end
    checks++;
    if (n !== 16 || promCnt - p0 !== 1) begin
      errors++;
      $display("[TB] FAIL edge_run: cycles=%0d prom=%0d want 16 1", n, promCnt - p0);
    end
  endtask

  task automatic test_abort();
    int n;
    startDownload();
    sendRange(16'h0000, 'h100);
    @(negedge clk_sys);
    ioctl_wr   = 1'b1;
    ioctl_addr = 16'h0100;
    ioctl_dout = pat(16'h0100);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (core_reset !== 1'b1 || {dn_wr_cpu, dn_wr_gfx, dn_wr_prom} !== 3'b000 ||
        dn_addr !== 16'h0 || dn_data !== 8'h0 || byte_count !== 17'h0 ||
        {load_ok, load_short, load_over} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL abort_clear: core_reset=%b addr=%h data=%h count=%h ok=%b want 1 0 0 0 0",
               core_reset, dn_addr, dn_data, byte_count, load_ok);
    end
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (20) @(posedge clk_sys);
    #1;
    checks++;
    if (core_reset !== 1'b1 || byte_count !== 17'h0) begin
      errors++;
      $display("[TB] FAIL abort_boot: core_reset=%b count=%h want 1 0", core_reset, byte_count);
    end
    startDownload();
    sendRange(16'h0000, 1);
    sendRange(16'h501F, 1);
    endDownload(n);
    checks++;
    if (load_ok !== 1'b1 || byte_count !== 17'h05020 || n !== 16) begin
      errors++;
      $display("[TB] FAIL abort_reload: ok=%b count=%h cycles=%0d want 1 05020 16",
               load_ok, byte_count, n);
    end
  endtask

  initial begin
    test_reset();
    test_idle_write();
    test_full_load();
    test_user_reset();
    test_short_load();
    test_over();
    test_edge_write();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
